// File: rtl/regfile_sb.sv
// regfile_sb: NREG x DW register file with two combinational read ports,
// one writeback port with same-cycle bypass, and a per-register pending
// scoreboard that gates instruction issue on RAW/WAW hazards.
module regfile_sb #(
  parameter int unsigned DW      = 8,
  parameter int unsigned NREG    = 8,
  parameter int unsigned ZERO_R0 = 0,
  localparam int unsigned AW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen,
  input  logic [AW-1:0]   rd,
  input  logic [DW-1:0]   din,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [DW-1:0]   r1,
  output logic [DW-1:0]   r2,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ok,
  input  logic            flush,
  output logic [NREG-1:0] busy
);

  localparam bit ZR = (ZERO_R0 != 0);

  logic [DW-1:0]   regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] eff_c;
  logic            wr_ok_c;
  logic            iss_ok_c;
  logic            iss_set_c;

  // A write to r0 is dropped entirely in the hardwired-zero build.
  assign wr_ok_c = wen && !(ZR && (rd == '0));

  // Storage: reset clears every word, otherwise commit the writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok_c) begin
      regs_q[rd] <= din;
    end
  end

  // Read port 1: zero-register override, then bypass, then storage.
  always_comb begin
    r1 = regs_q[rs1];
    if (wr_ok_c && (rd == rs1)) r1 = din;
    if (ZR && (rs1 == '0))      r1 = '0;
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    r2 = regs_q[rs2];
    if (wr_ok_c && (rd == rs2)) r2 = din;
    if (ZR && (rs2 == '0))      r2 = '0;
  end

  // Effective pending: a writeback landing this cycle already resolves its hazard.
  always_comb begin
    eff_c = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      eff_c[i] = busy_q[i] && !(wen && (rd == AW'(i)));
    end
  end

  // Issue is allowed only when no source or the destination is still pending.
  always_comb begin
    iss_ok_c  = !(eff_c[rs1] || eff_c[rs2] || eff_c[iss_rd]);
    iss_set_c = iss_en && iss_ok_c && !(ZR && (iss_rd == '0));
  end

  // Scoreboard next state: clear on writeback, younger issue wins, flush clears all.
  always_comb begin
    busy_d = busy_q;
    if (wen)       busy_d[rd]     = 1'b0;
    if (iss_set_c) busy_d[iss_rd] = 1'b1;
    if (flush)     busy_d         = '0;
    if (ZR)        busy_d[0]      = 1'b0;
  end

  // Scoreboard register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign iss_ok = iss_ok_c;
  assign busy   = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb: a default build and a
// ZERO_R0=1 build share the same stimulus.
module tb_regfile_sb;

  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;

  logic            clk;
  logic            rst;
  logic            wen;
  logic [AW-1:0]   rd;
  logic [DW-1:0]   din;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            iss_en;
  logic [AW-1:0]   iss_rd;
  logic            flush;
  logic [DW-1:0]   r1,  r2,  zr1,  zr2;
  logic            iss_ok, ziss_ok;
  logic [NREG-1:0] busy, zbusy;

  int n_pass;
  int n_total;

  typedef struct {
    logic            rst;
    logic            wen;
    logic [AW-1:0]   rd;
    logic [DW-1:0]   din;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic            flush;
    logic [DW-1:0]   exp_r1;
    logic [DW-1:0]   exp_r2;
    logic            exp_ok;
    logic [NREG-1:0] exp_busy;
  } vec_t;

  vec_t vecs[$];

  regfile_sb #(.DW(DW), .NREG(NREG), .ZERO_R0(0)) u_dut (
    .clk(clk), .rst(rst), .wen(wen), .rd(rd), .din(din),
    .rs1(rs1), .rs2(rs2), .r1(r1), .r2(r2),
    .iss_en(iss_en), .iss_rd(iss_rd), .iss_ok(iss_ok),
    .flush(flush), .busy(busy)
  );

  regfile_sb #(.DW(DW), .NREG(NREG), .ZERO_R0(1)) u_dut_z (
    .clk(clk), .rst(rst), .wen(wen), .rd(rd), .din(din),
    .rs1(rs1), .rs2(rs2), .r1(zr1), .r2(zr2),
    .iss_en(iss_en), .iss_rd(iss_rd), .iss_ok(ziss_ok),
    .flush(flush), .busy(zbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic w, input int d, input int dt,
                     input int a, input int b, input logic ie, input int ir,
                     input logic fl, input int e1, input int e2, input logic eo,
                     input int eb);
    vec_t v;
    v.rst = r;  v.wen = w;  v.rd = AW'(d);  v.din = DW'(dt);
    v.rs1 = AW'(a); v.rs2 = AW'(b); v.iss_en = ie; v.iss_rd = AW'(ir);
    v.flush = fl; v.exp_r1 = DW'(e1); v.exp_r2 = DW'(e2); v.exp_ok = eo;
    v.exp_busy = NREG'(eb);
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic w, input int d, input int dt,
                       input int a, input int b, input logic ie, input int ir,
                       input logic fl);
    rst = r; wen = w; rd = AW'(d); din = DW'(dt); rs1 = AW'(a); rs2 = AW'(b);
    iss_en = ie; iss_rd = AW'(ir); flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    //   rst wen rd din   rs1 rs2 ie ird fl  r1    r2    ok  busy
    add(0, 0, 0, 0,    0, 0, 0, 0, 0,  0,    0,    1,  'h00); // post-reset
    add(0, 1, 3, 'hA5, 1, 2, 0, 0, 0,  0,    0,    1,  'h00); // write r3
    add(0, 0, 0, 0,    3, 4, 0, 0, 0,  'hA5, 0,    1,  'h00);
    add(0, 0, 0, 0,    7, 0, 0, 0, 0,  0,    0,    1,  'h00);
    add(0, 1, 5, 'h3C, 3, 5, 0, 0, 0,  'hA5, 'h3C, 1,  'h00); // bypass r2
    add(0, 0, 0, 0,    5, 3, 0, 0, 0,  'h3C, 'hA5, 1,  'h00);
    add(0, 0, 0, 0,    0, 0, 1, 2, 0,  0,    0,    1,  'h00); // issue r2
    add(0, 0, 0, 0,    2, 0, 1, 6, 0,  0,    0,    0,  'h04); // RAW stall
    add(0, 1, 2, 'h77, 2, 0, 0, 6, 0,  'h77, 0,    1,  'h04); // eff clears
    add(0, 0, 0, 0,    2, 0, 0, 0, 0,  'h77, 0,    1,  'h00);
    add(0, 0, 0, 0,    0, 0, 1, 4, 0,  0,    0,    1,  'h00); // issue r4
    add(0, 1, 4, 'h11, 0, 0, 1, 4, 0,  0,    0,    1,  'h10); // set/clear collide
    add(0, 0, 0, 0,    4, 4, 0, 0, 0,  'h11, 'h11, 0,  'h10);
    add(0, 1, 4, 'h22, 0, 0, 0, 0, 0,  0,    0,    1,  'h10);
    add(0, 1, 6, 'h99, 6, 4, 0, 0, 0,  'h99, 'h22, 1,  'h00); // write non-busy
    add(0, 0, 0, 0,    0, 0, 1, 1, 0,  0,    0,    1,  'h00);
    add(0, 0, 0, 0,    0, 0, 1, 2, 0,  0,    0,    1,  'h02);
    add(0, 0, 0, 0,    0, 0, 1, 3, 0,  0,    0,    1,  'h06);
    add(0, 1, 3, 'h5A, 0, 0, 1, 6, 1,  0,    0,    1,  'h0E); // flush + issue + write
    add(0, 0, 0, 0,    3, 6, 0, 0, 0,  'h5A, 'h99, 1,  'h00);
    add(0, 0, 0, 0,    0, 0, 1, 7, 0,  0,    0,    1,  'h00);
    add(0, 1, 5, 'h66, 0, 0, 1, 1, 0,  0,    0,    1,  'h80);
    add(1, 1, 2, 'hEE, 5, 7, 0, 0, 0,  'h66, 0,    0,  'h82); // mid-op reset
    add(0, 0, 0, 0,    5, 2, 0, 0, 0,  0,    0,    1,  'h00);
    add(0, 0, 0, 0,    3, 4, 0, 0, 0,  0,    0,    1,  'h00);
    add(0, 0, 0, 0,    0, 0, 1, 3, 0,  0,    0,    1,  'h00);
    add(0, 0, 0, 0,    0, 0, 1, 3, 0,  0,    0,    0,  'h08); // WAW on iss_rd
    add(0, 0, 0, 0,    0, 0, 0, 0, 0,  0,    0,    1,  'h08);

    // Reset with a competing write must leave no residue.
    drive(1, 1, 1, 'h55, 0, 0, 1, 2, 1);
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wen, int'(vecs[i].rd), int'(vecs[i].din),
            int'(vecs[i].rs1), int'(vecs[i].rs2), vecs[i].iss_en,
            int'(vecs[i].iss_rd), vecs[i].flush);
      #2;
      check($sformatf("v%0d.r1", i),     32'(r1),     32'(vecs[i].exp_r1));
      check($sformatf("v%0d.r2", i),     32'(r2),     32'(vecs[i].exp_r2));
      check($sformatf("v%0d.iss_ok", i), 32'(iss_ok), 32'(vecs[i].exp_ok));
      check($sformatf("v%0d.busy", i),   32'(busy),   32'(vecs[i].exp_busy));
      tick();
    end

    // Hardwired-zero build against the default build on identical stimulus.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 'hFF, 0, 0, 0, 0, 0);
    #2;
    check("z.bypass_r0",   32'(zr1), 32'h0);
    check("d.bypass_r0",   32'(r1),  32'hFF);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    #2;
    check("z.read_r0",     32'(zr1), 32'h0);
    check("d.read_r0",     32'(r1),  32'hFF);
    check("z.iss_ok_r0",   32'(ziss_ok), 32'h1);
    tick();
    drive(0, 1, 1, 'h42, 0, 1, 0, 0, 0);
    #2;
    check("z.busy_r0",     32'(zbusy), 32'h00);
    check("d.busy_r0",     32'(busy),  32'h01);
    check("z.bypass_r1",   32'(zr2),   32'h42);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    #2;
    check("z.read_r1",     32'(zr1),   32'h42);
    check("z.busy_after",  32'(zbusy), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits.
REQ-002 SHALL have parameter NREG, default 8, number of registers, power of two, 2..64.
REQ-003 SHALL have parameter ZERO_R0, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-004 SHALL derive localparam AW = log2(NREG), the register-index width.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port wen  in  1  writeback enable.
REQ-008 SHALL have port rd  in  AW  writeback register index.
REQ-009 SHALL have port din  in  DW  writeback data.
REQ-010 SHALL have port rs1  in  AW  read port 1 index.
REQ-011 SHALL have port rs2  in  AW  read port 2 index.
REQ-012 SHALL have port r1  out  DW  read port 1 data.
REQ-013 SHALL have port r2  out  DW  read port 2 data.
REQ-014 SHALL have port iss_en  in  1  issue request; the instruction writes destination iss_rd.
REQ-015 SHALL have port iss_rd  in  AW  destination of the issuing instruction; also hazard-checked.
REQ-016 SHALL have port iss_ok  out  1  no hazard on rs1, rs2 or iss_rd; issue is accepted when iss_en && iss_ok.
REQ-017 SHALL have port flush  in  1  clear all pending bits.
REQ-018 SHALL have port busy  out  NREG  per-register pending (scoreboard) bits.

Function
REQ-019 SHALL hold NREG x DW storage words and an NREG-bit pending vector.
REQ-020 SHALL write din into regs[rd] at the clock edge when wen=1, except when ZERO_R0=1 and rd=0; such a write is discarded.
REQ-021 SHALL drive r1 and r2 combinationally, with zero-cycle latency.
REQ-022 SHALL bypass writes: when wen=1 and rd==rs1 (write not discarded), r1=din in the same cycle; r2 likewise with rs2.
REQ-023 SHALL force r1 (r2) to 0 when ZERO_R0=1 and rs1 (rs2) is 0, overriding bypass.
REQ-024 SHALL compute effective pending eff[i] = busy[i] && !(wen && rd==i).
REQ-025 SHALL drive iss_ok = !(eff[rs1] || eff[rs2] || eff[iss_ok_rd]), with iss_ok_rd = iss_rd; iss_ok is purely combinational and independent of iss_en.
REQ-026 SHALL set busy[iss_rd] at the edge when iss_en && iss_ok, except when ZERO_R0=1 and iss_rd=0.
REQ-027 SHALL clear busy[rd] at the edge when wen=1.
REQ-028 SHALL, when set and clear target the same register in one cycle, leave the bit set; the younger issue wins.
REQ-029 SHALL ignore iss_en when iss_ok=0; no state changes, and the requester retries.
REQ-030 SHALL clear every busy bit at the edge when flush=1; flush overrides a same-cycle issue set; a same-cycle register write still completes.
REQ-031 SHALL treat a wen to a register whose busy bit is 0 as legal: data is written and busy is unchanged.
REQ-032 SHALL keep busy[0]=0 permanently when ZERO_R0=1.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, clear all registers to 0 and all busy bits to 0; rst overrides wen, iss_en and flush.
REQ-034 SHALL output after reset: r1=r2=0, busy=0, and iss_ok=1.
REQ-035 SHALL apply reset asserted mid-operation, including with outstanding pending bits, at the next edge with no residual state.

Verification
REQ-036 SHALL cover write/read: after reset, wen=1, rd=3, din=8'hA5 for one cycle; next cycle rs1=3 -> r1=8'hA5, and all others read 0.
REQ-037 SHALL cover bypass: wen=1, rd=5, din=8'h3C, rs2=5 in the same cycle -> r2=8'h3C before the edge; regs[5]=8'h3C after the edge.
REQ-038 SHALL cover scoreboard: issue iss_rd=2 -> busy=8'h04; next cycle rs1=2 -> iss_ok=0 and iss_en is ignored; wen rd=2 in the same cycle -> iss_ok=1 (eff clears), and busy ends at 8'h00 unless re-issued.
REQ-039 SHALL cover set/clear collision: busy[4]=1; wen rd=4 and issue iss_rd=4 with rs1=rs2=0 in the same cycle -> iss_ok=1, and busy[4]=1 after the edge.
REQ-040 SHALL cover the ZERO_R0=1 build: wen rd=0, din=8'hFF, then rs1=0 -> r1=0; issue iss_rd=0 -> busy[0] stays 0.
REQ-041 SHALL cover flush/reset: busy=8'h0E and flush=1 with an issue to register 6 -> busy=8'h00; separately, rst=1 with wen=1 -> all registers 0 and busy=0.
